// File: rtl/alu_op_sequencer.sv
// Registered command front-end for a combinational ALU: accepts one operation,
// holds the ALU inputs for a fixed settle interval, then captures and presents the result.
module alu_op_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SEL_W  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SEL_W-1:0] in_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [15:0]      op_count,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on state; out_valid is a register; neither looks at the other side.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;

  assign in_ready  = (state == S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            alu_a   <= in_a;
            alu_b   <= in_b;
            alu_sel <= in_sel;
            cnt     <= CNT_INIT;
            state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // ALU inputs have been stable for SETTLE edges when cnt reaches 0.
          if (cnt == 4'd0) begin
            out_result <= alu_out;
            out_carry  <= alu_carry;
            out_zero   <= (alu_out == '0);
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered command front-end for the combinational `ALU_16bit`. It accepts one operation (A, B, select) per valid/ready handshake and drives the ALU inputs from registers. It waits a fixed settle interval so post-synthesis path delays can resolve, then captures `ALU_Out` and `CarryOut` into a result register. The captured result is presented downstream on a second valid/ready handshake.

## Interface
- `WIDTH`, 16: operand/result width; must match `ALU_16bit`
- `SEL_W`, 4: ALU select width
- `SETTLE`, 2: cycles from command acceptance to result capture; legal range 1..15
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `in_valid`  in  1  command present
- `in_ready`  out  1  sequencer can accept a command
- `in_a`, `in_b`  in  WIDTH  operands
- `in_sel`  in  SEL_W  ALU operation select
- `alu_a`, `alu_b`  out  WIDTH  registered operands to `ALU_16bit` A/B
- `alu_sel`  out  SEL_W  registered select to `ALU_16bit` ALU_Sel
- `alu_out`  in  WIDTH  from `ALU_16bit` ALU_Out
- `alu_carry`  in  1  from `ALU_16bit` CarryOut
- `out_valid`  out  1  captured result available
- `out_ready`  in  1  consumer takes result
- `out_result`  out  WIDTH  captured ALU result
- `out_carry`  out  1  captured carry
- `out_zero`  out  1  1 when captured result == 0
- `op_count`  out  16  completed operations; wraps modulo 2^16

## Operation
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - `in_ready`=1, combinational from state.
  - On an edge with `in_valid`&`in_ready`: load `alu_a`/`alu_b`/`alu_sel` from `in_a`/`in_b`/`in_sel`, load settle counter with SETTLE-1, go to SETTLE.
- SETTLE:
  - `in_ready`=0; `in_*` are ignored.
  - Counter decrements each edge.
  - On the edge where the counter is 0: capture `alu_out`→`out_result` and `alu_carry`→`out_carry`; set `out_zero`=(alu_out==0); set `out_valid`=1; go to DONE.
- DONE:
  - `out_valid`=1; `out_*` and `alu_*` hold stable.
  - On an edge with `out_valid`&`out_ready`: clear `out_valid`, increment `op_count`, go to IDLE.
- `alu_*` change only on command acceptance. Between commands they retain the last command.
- The sequencer does not decode `in_sel`. Every select value is passed to the ALU unchanged.
- `op_count` wraps 0xFFFF→0x0000 with no flag.
- Asynchronous reset mid-operation:
  - Any state goes to IDLE immediately.
  - Pending command and result are discarded.
  - All outputs take their reset values without waiting for a clock edge.

## Timing
- Reset values: state IDLE, `in_ready`=1 (follows IDLE), `alu_a`=`alu_b`=0, `alu_sel`=0, `out_valid`=0, `out_result`=0, `out_carry`=0, `out_zero`=0, `op_count`=0.
- Acceptance edge at cycle N: ALU inputs are valid from N. Capture occurs at edge N+SETTLE. `out_valid` is high from N+SETTLE.
- SETTLE=1: capture occurs on the first edge after acceptance.
- Output handshake at edge M: `in_ready` is 1 from M. The next acceptance is possible at edge M+1.
- Minimum issue interval is SETTLE+2 cycles with `out_ready` held 1.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- `out_ready` held low: DONE persists indefinitely and no command is accepted (backpressure).
- `in_valid` deasserting during SETTLE/DONE has no effect.

## Test plan
- Reset: assert `rst_n`=0 mid-SETTLE -> immediately `out_valid`=0, `alu_a`=0, `op_count`=0, `in_ready`=1.
- Single op, `ALU_16bit` in loop, SETTLE=2:
  - Stimulus: A=0x000A, B=0x0002, sel=4'h0 (add) accepted at edge N.
  - Required: `out_valid` rises at edge N+2 with `out_result`=0x000C, `out_carry`=0, `out_zero`=0. `op_count`=1 after handshake.
- Carry and zero:
  - Stimulus: A=0xFFFF, B=0x0001, sel=4'h0.
  - Required: `out_result`=0x0000, `out_carry`=1, `out_zero`=1.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles in DONE while `in_valid`=1 with new operands.
  - Required: `in_ready`=0 throughout; `out_result` and `alu_*` stable; the new command is accepted exactly one cycle after the output handshake.
- Sweep and throughput:
  - Stimulus: back-to-back commands, sel 4'h1..4'hC with A=0x00F6, B=0x00FF, `out_ready`=1.
  - Required: one result per SETTLE+2 cycles, each matching the ALU reference model; `op_count`=12.
- Counter wrap: preload or run 65536 handshakes -> `op_count` returns to 0x0000; the next op gives 0x0001.
